// File: rtl/sm_input_filter_pkg.sv
// sm_input_filter_pkg: shared default settings for the input filter slice
package sm_input_filter_pkg;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_CNT_WIDTH = 4;
    localparam int MIN_SYNC_STAGES = 2;
endpackage

// File: rtl/sm_filter_channel.sv
// sm_filter_channel: synchronizer chain, stability counter and edge pulses for one input bit
module sm_filter_channel
    import sm_input_filter_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
    parameter logic RESET_BIT = 1'b0
) (
    input logic clk,
    input logic rst_n,
    input logic d,
    input logic [CNT_WIDTH-1:0] filterLen,
    output logic q,
    output logic rise,
    output logic fall,
    output logic edgeNext
);
    logic [SYNC_STAGES-1:0] syncChain;
    logic [CNT_WIDTH-1:0] cnt;
    logic s;
    logic differ;
    logic expire;
    assign s = syncChain[SYNC_STAGES-1];
    assign differ = s != q;
    // >= lets a lowered filterLen take effect on the next differing cycle; cnt stops at filterLen
    assign expire = differ && cnt >= filterLen;
    assign edgeNext = expire;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncChain <= '0;
            cnt <= '0;
            q <= RESET_BIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], d};
            cnt <= differ && !expire ? cnt + 1'b1 : '0;
            q <= expire ? s : q;
            rise <= expire && s;
            fall <= expire && !s;
        end
    end
endmodule

// File: rtl/sm_input_filter.sv
// sm_input_filter: per-channel synchronizing glitch filter with edge pulses and a combined edge flag
module sm_input_filter
    import sm_input_filter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input logic clk,
    input logic rst_n,
    input logic [WIDTH-1:0] d,
    input logic [CNT_WIDTH-1:0] filterLen,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic anyEdge
);
    logic [WIDTH-1:0] edgeNext;
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_badSync
        $error("sm_input_filter: SYNC_STAGES must be at least 2");
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sm_filter_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_WIDTH(CNT_WIDTH),
            .RESET_BIT(RESET_VALUE[i])
        ) u_chan (
            .clk(clk),
            .rst_n(rst_n),
            .d(d[i]),
            .filterLen(filterLen),
            .q(q[i]),
            .rise(rise[i]),
            .fall(fall[i]),
            .edgeNext(edgeNext[i])
        );
    end
    // registered from the channels' next-cycle edge terms so it lines up with rise/fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) anyEdge <= 1'b0;
        else anyEdge <= |edgeNext;
    end
endmodule

// File: tb/tb_sm_input_filter.sv
// tb_sm_input_filter: directed scenarios plus randomized run against a history-based reference model
module tb_sm_input_filter;
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] d;
    logic [3:0] filterLen;
    logic [7:0] q;
    logic [7:0] rise;
    logic [7:0] fall;
    logic anyEdge;
    int checks = 0;
    int fails = 0;

    sm_input_filter dut (
        .clk(clk),
        .rst_n(rst_n),
        .d(d),
        .filterLen(filterLen),
        .q(q),
        .rise(rise),
        .fall(fall),
        .anyEdge(anyEdge)
    );

    always #5 clk = ~clk;

    // Model: q flips once the trailing run of synchronized samples differing from q reaches filterLen+1
    logic [7:0] m1, m2, mq, mRise, mFall;
    logic mAny;
    logic [7:0] hist[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= '0;
            m2 <= '0;
            mq <= '0;
            mRise <= '0;
            mFall <= '0;
            mAny <= 1'b0;
            hist.delete();
        end else begin : mdl
            logic [7:0] nq;
            int run;
            nq = mq;
            hist.push_back(m2);
            if (hist.size() > 40) void'(hist.pop_front());
            for (int i = 0; i < 8; i++) begin
                run = 0;
                for (int k = hist.size() - 1; k >= 0; k--) begin
                    if (hist[k][i] == mq[i]) break;
                    run++;
                end
                if (run >= int'(filterLen) + 1) nq[i] = m2[i];
            end
            mRise <= nq & ~mq;
            mFall <= ~nq & mq;
            mAny <= |(nq ^ mq);
            mq <= nq;
            m2 <= m1;
            m1 <= d;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        d = 8'hFF;
        filterLen = 4'd0;
        step(4);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00) begin fails++; $display("FAIL reset_q got %h exp 00", q); end
        checks++;
        if (rise !== 8'h00 || fall !== 8'h00) begin fails++; $display("FAIL reset_pulses got rise %h fall %h exp 00 00", rise, fall); end
        checks++;
        if (anyEdge !== 1'b0) begin fails++; $display("FAIL reset_anyEdge got %b exp 0", anyEdge); end
        step(2);
        checks++;
        if (q !== 8'h00) begin fails++; $display("FAIL reset_hold_q got %h exp 00", q); end
        d = 8'h00;
        filterLen = 4'd3;
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic test_stable_rise();
        d[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (k < 6 && (q[0] !== 1'b0 || rise[0] !== 1'b0)) begin
                fails++; $display("FAIL rise_early edge %0d got q0 %b rise0 %b exp 0 0", k, q[0], rise[0]);
            end else if (k == 6 && (q[0] !== 1'b1 || rise !== 8'h01 || anyEdge !== 1'b1)) begin
                fails++; $display("FAIL rise_edge6 got q0 %b rise %h any %b exp 1 01 1", q[0], rise, anyEdge);
            end else if (k == 7 && (q[0] !== 1'b1 || rise !== 8'h00 || anyEdge !== 1'b0)) begin
                fails++; $display("FAIL rise_after got q0 %b rise %h any %b exp 1 00 0", q[0], rise, anyEdge);
            end
        end
    endtask

    task automatic test_glitch();
        d[1] = 1'b1;
        step(3);
        d[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if ({q[1], rise[1], fall[1]} !== 3'b000) begin
                fails++; $display("FAIL glitch cycle %0d got q1/rise1/fall1 %b exp 000", k, {q[1], rise[1], fall[1]});
            end
        end
    endtask

    task automatic test_bypass();
        filterLen = 4'd0;
        d[2] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (k < 3 && q[2] !== 1'b0) begin fails++; $display("FAIL bypass_rise_early edge %0d got %b exp 0", k, q[2]); end
            else if (k == 3 && (q[2] !== 1'b1 || rise[2] !== 1'b1)) begin
                fails++; $display("FAIL bypass_rise got q2 %b rise2 %b exp 1 1", q[2], rise[2]);
            end
        end
        step(2);
        d[2] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (k < 3 && (q[2] !== 1'b1 || fall[2] !== 1'b0)) begin
                fails++; $display("FAIL bypass_fall_early edge %0d got q2 %b fall2 %b exp 1 0", k, q[2], fall[2]);
            end else if (k == 3 && (q[2] !== 1'b0 || fall[2] !== 1'b1)) begin
                fails++; $display("FAIL bypass_fall got q2 %b fall2 %b exp 0 1", q[2], fall[2]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int anyCount;
        filterLen = 4'd2;
        d = 8'h08;
        step(8);
        checks++;
        if (q !== 8'h08) begin fails++; $display("FAIL simul_setup got %h exp 08", q); end
        d = 8'h04;
        anyCount = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            anyCount += int'(anyEdge);
            if (k == 5) begin
                checks++;
                if (rise !== 8'h04 || fall !== 8'h08 || anyEdge !== 1'b1) begin
                    fails++; $display("FAIL simul_pulses got rise %h fall %h any %b exp 04 08 1", rise, fall, anyEdge);
                end
            end
        end
        checks++;
        if (anyCount !== 1 || q !== 8'h04) begin
            fails++; $display("FAIL simul_single got anyEdge count %0d q %h exp 1 04", anyCount, q);
        end
    endtask

    task automatic test_reset_mid_count();
        filterLen = 4'd15;
        d = 8'h00;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step(2);
        d = 8'h20;
        step(8);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00) begin fails++; $display("FAIL midreset_q got %h exp 00", q); end
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            checks++;
            if (k < 18 && q[5] !== 1'b0) begin
                fails++; $display("FAIL midreset_early edge %0d got q5 %b exp 0", k, q[5]);
            end else if (k == 18 && (q[5] !== 1'b1 || rise !== 8'h20)) begin
                fails++; $display("FAIL midreset_edge18 got q5 %b rise %h exp 1 20", q[5], rise);
            end
        end
    endtask

    task automatic test_random();
        rst_n = 1'b0;
        d = 8'($urandom);
        filterLen = 4'($urandom_range(0, 5));
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 39) == 0) filterLen = 4'($urandom_range(0, 6));
            d = d ^ 8'($urandom & $urandom & $urandom);
            step();
            checks++;
            if (q !== mq || rise !== mRise || fall !== mFall || anyEdge !== mAny) begin
                fails++;
                $display("FAIL random cycle %0d got q %h rise %h fall %h any %b exp %h %h %h %b",
                         k, q, rise, fall, anyEdge, mq, mRise, mFall, mAny);
            end
            checks++;
            if ((rise & fall) !== 8'h00) begin fails++; $display("FAIL random_exclusive cycle %0d got %h exp 00", k, rise & fall); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d = 8'h00;
        filterLen = 4'd0;
        step();
        test_reset();
        test_stable_rise();
        test_glitch();
        test_bypass();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sm_input_filter.md
SM_INPUT_FILTER -- requirements
Module: sm_input_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent input channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth; values below 2 are illegal.
REQ-003 SHALL have parameter CNT_WIDTH, default 4: width of filter-length input and per-channel counter.
REQ-004 SHALL have parameter RESET_VALUE, default {WIDTH{1'b0}}: reset value of the filtered output.
REQ-005 SHALL have port clk  input  1: single clock for all logic.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port d  input  WIDTH: asynchronous raw inputs (switches, buttons, extInput).
REQ-008 SHALL have port filterLen  input  CNT_WIDTH: required stability length; quasi-static, sampled every cycle.
REQ-009 SHALL have port q  output  WIDTH: filtered, registered channel values.
REQ-010 SHALL have port rise  output  WIDTH: one-cycle pulse per channel on q 0->1.
REQ-011 SHALL have port fall  output  WIDTH: one-cycle pulse per channel on q 1->0.
REQ-012 SHALL have port anyEdge  output  1: registered OR of all rise and fall bits in the same cycle.

Function
REQ-013 SHALL pass each d bit through SYNC_STAGES flops; last stage is s[i]; no logic between stages.
REQ-014 SHALL hold per-channel counter cnt[i] of CNT_WIDTH bits.
REQ-015 SHALL, each cycle with s[i]==q[i]: cnt[i]<=0, q[i] held, no pulse.
REQ-016 SHALL, each cycle with s[i]!=q[i] and cnt[i]>=filterLen: q[i]<=s[i], cnt[i]<=0, pulse on rise[i] or fall[i] per direction.
REQ-017 SHALL, each cycle with s[i]!=q[i] and cnt[i]<filterLen: cnt[i]<=cnt[i]+1, q[i] held.
REQ-018 SHALL therefore update q[i] only after s[i] differs for filterLen+1 consecutive cycles; latency from d change (setup met) to q change = SYNC_STAGES+filterLen+1 clk edges.
REQ-019 SHALL bypass filtering with filterLen==0: q follows s with one cycle delay, still producing pulses.
REQ-020 SHALL use >= compare so filterLen lowered mid-count completes on next differing cycle; cnt never wraps.
REQ-021 SHALL discard pulses shorter than filterLen+1 synchronized cycles with no q change and no pulse.
REQ-022 SHALL assert rise/fall in the same cycle q changes, for exactly one cycle; rise[i] and fall[i] never both high.
REQ-023 SHALL treat channels independently; simultaneous events on several channels all reported same cycle.
REQ-024 SHALL assert anyEdge in the same cycle as the pulses it summarizes.

Reset
REQ-025 SHALL on rst_n low, immediately: sync flops 0, cnt 0, q=RESET_VALUE, rise=fall=0, anyEdge=0.
REQ-026 SHALL on reset mid-count discard partial counts; after release full REQ-018 latency applies.
REQ-027 SHALL, if synchronized input differs from RESET_VALUE after release, update q normally with pulses.

Structure
REQ-028 SHALL keep default parameters (SYNC_STAGES, CNT_WIDTH) as shared constants in the common settings include.
REQ-029 SHALL instantiate one sub-module sm_filter_channel (sync chain, counter, q, rise, fall for one bit) WIDTH times via generate.
REQ-030 SHALL compute anyEdge in the top-level wrapper only.

Verification (WIDTH=8, SYNC_STAGES=2, CNT_WIDTH=4, RESET_VALUE=0)
REQ-031 SHALL cover reset: rst_n=0, d=8'hFF -> q=8'h00, rise=fall=0, anyEdge=0 without clock edge.
REQ-032 SHALL cover stable rise: filterLen=3, d[0] 0->1 held -> q[0]=1 and rise[0]=1 for one cycle exactly 6 edges later, anyEdge=1 same cycle.
REQ-033 SHALL cover glitch: filterLen=3, d[1] high 3 cycles then low -> q[1] stays 0, no pulses.
REQ-034 SHALL cover bypass: filterLen=0, d[2] 0->1 -> q[2]=1 after 3 edges; then 1->0 -> fall[2] pulse 3 edges later.
REQ-035 SHALL cover simultaneous: q=8'h08, d changes to 8'h04 -> rise[2] and fall[3] same cycle, single anyEdge pulse.
REQ-036 SHALL cover reset mid-count: filterLen=15, rst_n pulsed low after 8 cycles of change -> q=0 held; after release change needs full 18 edges.
